// File: rtl/regfile_serial_bank.sv
// rtl/regfile_serial_bank.sv - bit-serial register file with rs1/rs2/rd addressing and pass sequencer
//
// Purpose: holds REG_COUNT registers of REG_WIDTH bits. A pass streams two
// operands out LSB-first, one bit per cycle. In the same pass it can write a
// result stream back into rd. There is also a parallel load port and a
// combinational full-word read of rs1_addr.
//
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   start                      begin a pass (honoured only when idle)
//   rs1_addr/rs2_addr/rd_addr  operand and destination indices, latched on start
//   wr_en                      pass writes wr_bit into rd, latched on start
//   wr_bit                     result bit for the current bit_index
//   load_en/load_addr/load_data  parallel store, honoured only when idle
//   rs1_bit/rs2_bit            serial operand bits during a pass, else 0
//   rs1_word                   live full word of regs[rs1_addr]
//   bit_index                  current bit position of the pass
//   busy                       pass in progress
//   done                       one-cycle pulse after the last bit
module regfile_serial_bank #(
    parameter int REG_WIDTH = 8,
    parameter int REG_COUNT = 8,
    parameter int ZERO_REG  = 1,
    localparam int AW = $clog2(REG_COUNT),
    localparam int IW = $clog2(REG_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [AW-1:0]        rs1_addr,
    input  logic [AW-1:0]        rs2_addr,
    input  logic [AW-1:0]        rd_addr,
    input  logic                 wr_en,
    input  logic                 wr_bit,
    input  logic                 load_en,
    input  logic [AW-1:0]        load_addr,
    input  logic [REG_WIDTH-1:0] load_data,
    output logic                 rs1_bit,
    output logic                 rs2_bit,
    output logic [REG_WIDTH-1:0] rs1_word,
    output logic [IW-1:0]        bit_index,
    output logic                 busy,
    output logic                 done
);

    // Storage covers every encodable index. Slots that are not writable
    // (r0 when hardwired, and indices >= REG_COUNT) reset to zero and are never
    // written. That makes "reads return 0" fall out of a plain array read.
    localparam int NSLOT = 2 ** AW;
    localparam logic [IW-1:0] LAST_BIT = IW'(REG_WIDTH - 1);

    function automatic logic slot_writable(input int r);
        return (r < REG_COUNT) && !((ZERO_REG != 0) && (r == 0));
    endfunction

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t state;
    state_t state_next;

    logic [REG_WIDTH-1:0] regs [NSLOT];
    logic [AW-1:0]        rs1_l;
    logic [AW-1:0]        rs2_l;
    logic [AW-1:0]        rd_l;
    logic                 wr_en_l;

    logic accept_start;
    logic last_bit;
    logic load_hit;
    logic shift_wr;

    assign accept_start = (state == IDLE) && start;
    assign last_bit     = (state == SHIFT) && (bit_index == LAST_BIT);
    assign load_hit     = (state == IDLE) && load_en;
    assign shift_wr     = (state == SHIFT) && wr_en_l;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start)    state_next = SHIFT;
            SHIFT: if (last_bit) state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rs1_l     <= '0;
            rs2_l     <= '0;
            rd_l      <= '0;
            wr_en_l   <= 1'b0;
            bit_index <= '0;
            done      <= 1'b0;
        end else begin
            done <= last_bit;
            if (accept_start) begin
                rs1_l     <= rs1_addr;
                rs2_l     <= rs2_addr;
                rd_l      <= rd_addr;
                wr_en_l   <= wr_en;
                bit_index <= '0;
            end else if (last_bit) begin
                bit_index <= '0;
            end else if (state == SHIFT) begin
                bit_index <= bit_index + IW'(1);
            end
        end
    end

    // Loads happen only in IDLE and serial writes only in SHIFT, so the two
    // never target the same edge. A load that coincides with an accepted start
    // commits before the pass makes its first read.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < NSLOT; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NSLOT; r++) begin
                if (slot_writable(r)) begin
                    if (load_hit && (load_addr == AW'(r))) begin
                        regs[r] <= load_data;
                    end
                    if (shift_wr && (rd_l == AW'(r))) begin
                        regs[r][bit_index] <= wr_bit;
                    end
                end
            end
        end
    end

    // Serial reads see the pre-edge contents. For an in-place pass (rd == rs),
    // the current bit is therefore still the original value.
    assign busy     = (state == SHIFT);
    assign rs1_bit  = busy ? regs[rs1_l][bit_index] : 1'b0;
    assign rs2_bit  = busy ? regs[rs2_l][bit_index] : 1'b0;
    assign rs1_word = regs[rs1_addr];

endmodule

// File: tb/tb_regfile_serial_bank.sv
// tb/tb_regfile_serial_bank.sv - self-checking bench for regfile_serial_bank
module tb_regfile_serial_bank;

    localparam int W  = 8;
    localparam int N  = 8;
    localparam int AW = 3;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic [AW-1:0] rs1_addr, rs2_addr, rd_addr;
    logic          wr_en, wr_bit, load_en;
    logic [AW-1:0] load_addr;
    logic [W-1:0]  load_data;
    logic          rs1_bit, rs2_bit;
    logic [W-1:0]  rs1_word;
    logic [IW-1:0] bit_index;
    logic          busy, done;

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] model [N];

    regfile_serial_bank #(.REG_WIDTH(W), .REG_COUNT(N), .ZERO_REG(1)) dut (
        .clk(clk), .rstn(rstn), .start(start),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .wr_en(wr_en), .wr_bit(wr_bit),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .rs1_bit(rs1_bit), .rs2_bit(rs2_bit), .rs1_word(rs1_word),
        .bit_index(bit_index), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mread(input int idx);
        if (idx == 0 || idx >= N) return '0;
        return model[idx];
    endfunction

    function automatic void mwrite(input int idx, input logic [W-1:0] v);
        if (idx != 0 && idx < N) model[idx] = v;
    endfunction

    task automatic idle_inputs();
        start = 0; wr_en = 0; wr_bit = 0; load_en = 0;
        load_addr = '0; load_data = '0;
    endtask

    task automatic check_all_regs(input string tag);
        for (int a = 0; a < N; a++) begin
            rs1_addr = AW'(a);
            #1;
            vectors++;
            if (rs1_word !== mread(a)) begin
                miscompares++;
                $display("FAIL %s r%0d: got %h expected %h", tag, a, rs1_word, mread(a));
            end
        end
    endtask

    task automatic do_load(input int addr, input logic [W-1:0] data);
        @(negedge clk);
        load_en = 1; load_addr = AW'(addr); load_data = data;
        @(negedge clk);
        load_en = 0;
        mwrite(addr, data);
    endtask

    // Runs one pass starting at the current negedge and returns in the done cycle.
    // mode: 0 random wr_bit, 1 inverted expected rs1 bit, 2 all ones.
    // hold: keep start high and scramble inputs and issue loads during SHIFT.
    // ld:   also issue a parallel load in the start cycle.
    task automatic run_pass(input int rs1, input int rs2, input int rd, input logic we,
                            input int mode, input bit hold, input bit ld,
                            input int ld_addr, input logic [W-1:0] ld_data,
                            output logic [W-1:0] got1, output logic [W-1:0] got2);
        logic [W-1:0] exp1, exp2;
        logic         b;
        start = 1; rs1_addr = AW'(rs1); rs2_addr = AW'(rs2); rd_addr = AW'(rd); wr_en = we;
        load_en = ld; load_addr = AW'(ld_addr); load_data = ld_data;
        if (ld) mwrite(ld_addr, ld_data);
        exp1 = mread(rs1);
        exp2 = mread(rs2);
        @(negedge clk);
        start = hold; load_en = 0;
        for (int i = 0; i < W; i++) begin
            if (hold) begin
                rs1_addr = AW'($urandom_range(0, N - 1));
                rs2_addr = AW'($urandom_range(0, N - 1));
                rd_addr  = AW'($urandom_range(0, N - 1));
                wr_en = ~we;
                load_en = 1; load_addr = AW'($urandom_range(0, N - 1)); load_data = W'($urandom);
            end
            #1;
            got1[i] = rs1_bit;
            got2[i] = rs2_bit;
            vectors++;
            if (busy !== 1'b1 || done !== 1'b0 || bit_index !== IW'(i)) begin
                miscompares++;
                $display("FAIL pass_ctrl bit%0d: busy=%b done=%b idx=%0d expected 1 0 %0d",
                         i, busy, done, bit_index, i);
            end
            vectors++;
            if (rs1_bit !== exp1[i] || rs2_bit !== exp2[i]) begin
                miscompares++;
                $display("FAIL pass_bits bit%0d: rs1=%b rs2=%b expected %b %b",
                         i, rs1_bit, rs2_bit, exp1[i], exp2[i]);
            end
            if (!hold) begin
                vectors++;
                if (rs1_word !== mread(rs1)) begin
                    miscompares++;
                    $display("FAIL pass_word bit%0d: got %h expected %h", i, rs1_word, mread(rs1));
                end
            end
            case (mode)
                0: b = 1'($urandom);
                1: b = ~exp1[i];
                default: b = 1'b1;
            endcase
            wr_bit = b;
            @(negedge clk);
            if (we) begin
                logic [W-1:0] v;
                v = mread(rd);
                v[i] = b;
                mwrite(rd, v);
            end
        end
        load_en = 0;
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || bit_index !== '0 || rs1_bit !== 1'b0) begin
            miscompares++;
            $display("FAIL pass_done: done=%b busy=%b idx=%0d rs1_bit=%b expected 1 0 0 0",
                     done, busy, bit_index, rs1_bit);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rs1_addr = '0; rs2_addr = '0; rd_addr = '0;
        rstn = 0;
        for (int a = 0; a < N; a++) model[a] = '0;
        repeat (2) @(negedge clk);
        rstn = 1;
        @(negedge clk);
        vectors++;
        if (busy !== 0 || done !== 0 || bit_index !== '0 || rs1_bit !== 0 || rs2_bit !== 0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b done=%b idx=%0d bits=%b%b expected all 0",
                     busy, done, bit_index, rs1_bit, rs2_bit);
        end
        check_all_regs("reset_regs");
    endtask

    task automatic test_load();
        do_load(3, 8'hA5);
        do_load(5, 8'h3C);
        rs1_addr = 3; #1;
        vectors++;
        if (rs1_word !== 8'hA5) begin
            miscompares++;
            $display("FAIL load_r3: got %h expected a5", rs1_word);
        end
        rs1_addr = 5; #1;
        vectors++;
        if (rs1_word !== 8'h3C || busy !== 0 || done !== 0) begin
            miscompares++;
            $display("FAIL load_r5: got %h busy=%b done=%b expected 3c 0 0", rs1_word, busy, done);
        end
    endtask

    task automatic test_read_pass();
        logic [W-1:0] g1, g2;
        @(negedge clk);
        run_pass(3, 5, 1, 1'b0, 0, 0, 0, 0, '0, g1, g2);
        vectors++;
        if (g1 !== 8'hA5 || g2 !== 8'h3C) begin
            miscompares++;
            $display("FAIL read_stream: rs1 %h rs2 %h expected a5 3c", g1, g2);
        end
        start = 0;
        @(negedge clk);
        vectors++;
        if (done !== 0) begin
            miscompares++;
            $display("FAIL done_width: done=%b expected 0", done);
        end
        check_all_regs("read_unchanged");
    endtask

    task automatic test_inplace();
        logic [W-1:0] g1, g2;
        @(negedge clk);
        run_pass(3, 5, 3, 1'b1, 1, 0, 0, 0, '0, g1, g2);
        start = 0;
        vectors++;
        if (g1 !== 8'hA5) begin
            miscompares++;
            $display("FAIL inplace_stream: got %h expected a5", g1);
        end
        @(negedge clk);
        rs1_addr = 3; #1;
        vectors++;
        if (rs1_word !== 8'h5A || done !== 0) begin
            miscompares++;
            $display("FAIL inplace_result: r3 %h done=%b expected 5a 0", rs1_word, done);
        end
    endtask

    task automatic test_zero_reg();
        logic [W-1:0] g1, g2;
        do_load(0, 8'hFF);
        rs1_addr = 0; #1;
        vectors++;
        if (rs1_word !== 8'h00) begin
            miscompares++;
            $display("FAIL zero_load: r0 %h expected 00", rs1_word);
        end
        @(negedge clk);
        run_pass(0, 0, 0, 1'b1, 2, 0, 0, 0, '0, g1, g2);
        start = 0;
        vectors++;
        if (g1 !== 8'h00 || rs1_word !== 8'h00) begin
            miscompares++;
            $display("FAIL zero_serial: stream %h word %h expected 00 00", g1, rs1_word);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] g1, g2;
        do_load(6, 8'h96);
        do_load(7, 8'h21);
        @(negedge clk);
        run_pass(6, 7, 4, 1'b0, 0, 1, 0, 0, '0, g1, g2);
        run_pass(7, 6, 6, 1'b1, 0, 0, 0, 0, '0, g1, g2);
        start = 0;
        vectors++;
        if (g1 !== 8'h21 || g2 !== 8'h96) begin
            miscompares++;
            $display("FAIL b2b_second: rs1 %h rs2 %h expected 21 96", g1, g2);
        end
        @(negedge clk);
        check_all_regs("b2b_regs");
        @(negedge clk);
        run_pass(2, 3, 1, 1'b0, 0, 0, 1, 2, 8'hC3, g1, g2);
        start = 0;
        vectors++;
        if (g1 !== 8'hC3) begin
            miscompares++;
            $display("FAIL load_with_start: rs1 stream %h expected c3", g1);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [W-1:0] g1, g2;
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 2) == 0) do_load($urandom_range(0, N - 1), W'($urandom));
            @(negedge clk);
            run_pass($urandom_range(0, N - 1), $urandom_range(0, N - 1), $urandom_range(0, N - 1),
                     1'($urandom), 0, 0, 1'($urandom_range(0, 3) == 0),
                     $urandom_range(0, N - 1), W'($urandom), g1, g2);
            start = 0;
        end
        @(negedge clk);
        check_all_regs("random_regs");
    endtask

    task automatic test_reset_midpass();
        logic b;
        do_load(2, 8'h0F);
        @(negedge clk);
        start = 1; rs1_addr = 2; rs2_addr = 2; rd_addr = 2; wr_en = 1; wr_bit = 1;
        @(negedge clk);
        start = 0;
        repeat (4) @(negedge clk);
        vectors++;
        if (bit_index !== 3'd4 || busy !== 1) begin
            miscompares++;
            $display("FAIL midpass_pos: idx=%0d busy=%b expected 4 1", bit_index, busy);
        end
        b = 0;
        #2 rstn = 0;
        #1;
        vectors++;
        if (busy !== 0 || done !== 0 || bit_index !== '0 || rs1_bit !== 0) begin
            miscompares++;
            $display("FAIL midpass_reset: busy=%b done=%b idx=%0d rs1_bit=%b expected 0 0 0 %b",
                     busy, done, bit_index, rs1_bit, b);
        end
        for (int a = 0; a < N; a++) model[a] = '0;
        idle_inputs();
        @(negedge clk);
        rstn = 1;
        @(negedge clk);
        check_all_regs("midpass_regs");
    endtask

    initial begin
        rs1_addr = '0; rs2_addr = '0; rd_addr = '0;
        idle_inputs();
        test_reset();
        test_load();
        test_read_pass();
        test_inplace();
        test_zero_reg();
        test_back_to_back();
        test_random();
        test_reset_midpass();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_serial_bank.md
Name: regfile_serial_bank

Overview:
Parametrised bit-serial register file for the bit-serial CPU datapath. It adds the following to the existing single-index serial file:
- independent rs1/rs2/rd addressing;
- a start/busy/done pass sequencer;
- serial LSB-first write-back into rd;
- optional hardwired-zero r0;
- explicit parallel load port.

It sits between the decoder/sequencer and the serial ALU. Per pass it streams two operands out one bit per cycle while accepting the result stream.

Parameters:
REG_WIDTH, 8, bits per register; any value >= 2, power of two not required.
REG_COUNT, 8, number of registers; >= 2.
ZERO_REG, 1, when 1 register 0 always reads 0 and ignores all writes.
(Derived localparams: AW = $clog2(REG_COUNT), IW = $clog2(REG_WIDTH).)

Ports:
clk  input  1  system clock, all state on rising edge.
rstn  input  1  asynchronous active-low reset.
start  input  1  request a serial pass; sampled only when idle.
rs1_addr  input  AW  source 1 index, latched on accepted start.
rs2_addr  input  AW  source 2 index, latched on accepted start.
rd_addr  input  AW  destination index, latched on accepted start.
wr_en  input  1  pass writes wr_bit stream into rd; latched on accepted start.
wr_bit  input  1  result bit for current bit_index during pass.
load_en  input  1  parallel store request.
load_addr  input  AW  parallel store index.
load_data  input  REG_WIDTH  parallel store value.
rs1_bit  output  1  bit bit_index of latched rs1 during pass, else 0.
rs2_bit  output  1  bit bit_index of latched rs2 during pass, else 0.
rs1_word  output  REG_WIDTH  combinational full word of regs[rs1_addr] (live input), always valid.
bit_index  output  IW  current bit position.
busy  output  1  pass in progress.
done  output  1  one-cycle pulse after last bit.

Behaviour:
- Reset (async, rstn=0): all registers 0, state IDLE, bit_index 0, busy 0, done 0, latched addresses/wr_en 0. rs1_bit/rs2_bit read 0.
- Reset mid-pass aborts immediately; no partial result survives because all registers clear.
- FSM has two states: IDLE and SHIFT.
- IDLE with start=1: latch rs1/rs2/rd/wr_en, bit_index<=0, go to SHIFT, busy<=1.
- SHIFT, each cycle:
  - rs1_bit = regs[rs1_l][bit_index] and rs2_bit = regs[rs2_l][bit_index], combinational.
  - If wr_en_l, regs[rd_l][bit_index] <= wr_bit at the edge.
  - bit_index increments.
- SHIFT with bit_index==REG_WIDTH-1: at that edge go to IDLE, bit_index<=0, busy<=0, done<=1 for exactly one cycle.
- Timing: start accepted at edge k gives bits 0..REG_WIDTH-1 in cycles k+1..k+REG_WIDTH, and done is high in cycle k+REG_WIDTH+1.
- start asserted in the done cycle is accepted, so back-to-back passes have no gap.
- start while busy is ignored; latched addresses are unchanged.
- rd equal to rs1 or rs2 (in-place): the read returns the pre-write value of the current bit. Bits > bit_index are still unwritten, so the operand stream is the original value.
- ZERO_REG=1: any read of index 0 (serial or rs1_word) returns 0. Serial writes and loads to index 0 are dropped.
- load_en is honoured only in IDLE; it is ignored while busy, and no error is flagged.
- load_en and accepted start in the same IDLE cycle: the load commits at that edge. The pass reads the loaded value, because its first read is the following cycle.
- Addresses >= REG_COUNT (non-power-of-two count): reads return 0, writes/loads dropped.
- rs1_word is unaffected by the FSM. It reflects current contents, including bits already written in an in-progress pass.

Test Plan:
1. Reset, then load r3=0xA5 and r5=0x3C with start=0 -> rs1_word=0xA5 for rs1_addr=3 and 0x3C for rs1_addr=5; busy=0, done=0.
2. start with rs1=3, rs2=5, wr_en=0 -> cycles 1..8 give rs1_bit 1,0,1,0,0,1,0,1 and rs2_bit 0,0,1,1,1,1,0,0; done pulses in cycle 9; registers unchanged.
3. start with rs1=3, rd=3, wr_en=1, wr_bit = inverted rs1_bit -> stream reads original 0xA5 bits; afterwards r3=0x5A; done pulses once.
4. load r0=0xFF, then serial write of ones to rd=0 -> r0 reads 0x00 throughout (ZERO_REG=1); rs1_bit from r0 is 0.
5. Pulse start again in the done cycle and hold start high during SHIFT -> second pass starts with no gap; extra start and a load_en during SHIFT are both ignored (target register unchanged).
6. Assert rstn=0 at bit 4 of a write pass to r2 (preloaded 0x0F) -> busy/done/bit_index=0 immediately; r2=0x00 after reset.
